// File: rtl/life_pkg.sv
// Shared types and default rule masks for the Game-of-Life row engine.
// count_live() is the single neighbour-count definition used by every cell.
package life_pkg;

    typedef logic [3:0] count_t;

    localparam logic [8:0] DEFAULT_BIRTH   = 9'b000001000;
    localparam logic [8:0] DEFAULT_SURVIVE = 9'b000001100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic count_t count_live(input logic [7:0] nbrs);
        count_t n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, nbrs[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// One cell of the next-generation row: counts its 8 neighbours and applies
// the birth mask to a dead cell or the survive mask to a live one.
module life_cell_rule
    import life_pkg::*;
(
    input  logic [7:0] nbrs,
    input  logic       self_cell,
    input  logic [8:0] birth_mask,
    input  logic [8:0] survive_mask,
    output logic       next_cell
);

    count_t n;

    always_comb begin
        n         = count_live(nbrs);
        next_cell = self_cell ? survive_mask[n] : birth_mask[n];
    end

endmodule

// File: rtl/life_row_engine.sv
// Streaming Game-of-Life engine: 3-row window (above, mid, incoming row) feeding
// a row of cell rules, with a single registered output slot.
module life_row_engine
    import life_pkg::*;
#(
    parameter int         WIDTH        = 16,
    parameter int         WRAP         = 0,
    parameter logic [8:0] BIRTH_MASK   = DEFAULT_BIRTH,
    parameter logic [8:0] SURVIVE_MASK = DEFAULT_SURVIVE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_row,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_row,
    output logic                       out_last,
    output logic [$clog2(WIDTH+1)-1:0] out_pop,
    output state_t                     dbg_state
);

    localparam int PW = $clog2(WIDTH + 1);

    // Both ports: a beat transfers on the rising edge where valid and ready are
    // both high; valid never waits on ready, and payload is held while valid && !ready.
    state_t           state, state_nxt;
    logic [WIDTH-1:0] above, mid, below, nxt_row;
    logic [PW-1:0]    nxt_pop;
    logic             slot_free, accept, load_slot, load_last;

    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = in_last ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (accept && in_last) state_nxt = ST_FLUSH;
            ST_FLUSH: if (slot_free) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The row below is the incoming beat while running, all-dead when flushing.
    always_comb begin
        in_ready  = 1'b0;
        load_slot = 1'b0;
        load_last = 1'b0;
        below     = '0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN: begin
                in_ready  = slot_free;
                load_slot = accept;
                below     = in_row;
            end
            ST_FLUSH: begin
                load_slot = slot_free;
                load_last = 1'b1;
            end
            default: ;
        endcase
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_cell
        logic [2:0] lcol, rcol;
        if (c == 0) begin : g_left_edge
            if (WRAP != 0) assign lcol = {above[WIDTH-1], mid[WIDTH-1], below[WIDTH-1]};
            else           assign lcol = 3'b000;
        end else begin : g_left
            assign lcol = {above[c-1], mid[c-1], below[c-1]};
        end
        if (c == WIDTH - 1) begin : g_right_edge
            if (WRAP != 0) assign rcol = {above[0], mid[0], below[0]};
            else           assign rcol = 3'b000;
        end else begin : g_right
            assign rcol = {above[c+1], mid[c+1], below[c+1]};
        end
        life_cell_rule u_rule (
            .nbrs        ({lcol, rcol, above[c], below[c]}),
            .self_cell   (mid[c]),
            .birth_mask  (BIRTH_MASK),
            .survive_mask(SURVIVE_MASK),
            .next_cell   (nxt_row[c])
        );
    end

    always_comb begin
        nxt_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nxt_pop = nxt_pop + {{(PW-1){1'b0}}, nxt_row[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            above <= '0;
            mid   <= '0;
        end else if (accept) begin
            above <= (state == ST_IDLE) ? '0 : mid;
            mid   <= in_row;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            out_pop   <= '0;
        end else if (load_slot) begin
            out_valid <= 1'b1;
            out_row   <= nxt_row;
            out_last  <= load_last;
            out_pop   <= nxt_pop;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
